// File: rtl/serial_adder_pkg.sv
// Shared types and elaboration-time helpers for the bit-serial adder/subtractor.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int nsteps(input int width, input int digit);
        return width / digit;
    endfunction

    // A counter never shrinks below one bit, even for a single-step datapath.
    function automatic int cnt_width(input int steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

    function automatic bit digit_ok(input int width, input int digit);
        return (width > 0) && (digit > 0) && (width % digit == 0);
    endfunction

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_DIGIT  = 1;
    localparam int DEF_NSTEPS = DEF_WIDTH / DEF_DIGIT;
    localparam int DEF_CNT_W  = (DEF_NSTEPS > 1) ? $clog2(DEF_NSTEPS) : 1;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/ripple_digit_adder.sv
// Combinational DIGIT-bit ripple-carry adder built from full_adder cells.
module ripple_digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout
);

    logic [DIGIT:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .s    (s[i]),
            .cout (c[i+1])
        );
    end

    assign cout = c[DIGIT];

endmodule

// File: rtl/serial_adder_sub.sv
// Bit-serial adder/subtractor: DIGIT bits per cycle, valid/ready on both sides.
// State | meaning: IDLE waits for operands, RUN shifts digits, DONE presents the result.
module serial_adder_sub
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSTEPS = nsteps(WIDTH, DIGIT);
    localparam int CNT_W  = cnt_width(NSTEPS);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NSTEPS - 1);

    if (!digit_ok(WIDTH, DIGIT)) begin : g_bad_params
        $error("serial_adder_sub: WIDTH must be a positive multiple of DIGIT");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             amsb_q, amsb_d;
    logic             bmsb_q, bmsb_d;

    logic [DIGIT-1:0] dig_s;
    logic             dig_cout;
    logic             accept;

    ripple_digit_adder #(.DIGIT(DIGIT)) u_digit (
        .a    (opa_q[DIGIT-1:0]),
        .b    (opb_q[DIGIT-1:0]),
        .cin  (carry_q),
        .s    (dig_s),
        .cout (dig_cout)
    );

    assign in_ready  = rst_n && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        amsb_d  = amsb_q;
        bmsb_d  = bmsb_q;

        case (state_q)
            RUN: begin
                opa_d   = opa_q >> DIGIT;
                opb_d   = opb_q >> DIGIT;
                sum_d   = (sum_q >> DIGIT) | (WIDTH'(dig_s) << (WIDTH - DIGIT));
                carry_d = dig_cout;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d = DONE;
                    cout_d  = dig_cout;
                    // The last digit's MSB is the final sum's MSB.
                    ovf_d   = (amsb_q == bmsb_q) && (dig_s[DIGIT-1] != amsb_q);
                end
            end
            DONE: begin
                if (out_ready && !in_valid) begin
                    state_d = IDLE;
                end
            end
            default: ;
        endcase

        // Subtraction is a + ~b + 1, with the +1 entering as the initial carry.
        if (accept) begin
            state_d = RUN;
            opa_d   = a;
            opb_d   = sub ? ~b : b;
            carry_d = sub;
            cnt_d   = '0;
            amsb_d  = a[WIDTH-1];
            bmsb_d  = b[WIDTH-1] ^ sub;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            amsb_q  <= 1'b0;
            bmsb_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            amsb_q  <= amsb_d;
            bmsb_q  <= bmsb_d;
        end
    end

endmodule
